// File: rtl/wm_write_arbiter.sv
// ---------------------------------------------------------------------------
// wm_write_arbiter
//
// Round-robin arbiter for the single write port of the 2R1W working memory.
// The init engine, the relaxation lanes and the distance-copy engine all
// write through this block. At most one write is issued per clock. Each
// accepted write is registered onto WMWE/WMWAR/WMWDR, so the SRAM commits
// it at the following edge.
//
// Handshake: requester i has a write pending while req_valid[i]=1. It must
// hold req_addr/req_data stable, and keep valid high, until it sees
// req_valid[i] & req_ready[i] at a rising edge. That edge accepts the write.
// req_ready is one-hot or zero, is combinational, and is never 1 for a
// requester whose valid is 0.
//
// Ports
//   clock      in   1        system clock, rising edge
//   reset      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     write pending per requester
//   req_addr   in   NREQ*AW  requester i address at [i*AW +: AW]
//   req_data   in   NREQ*DW  requester i data at [i*DW +: DW]
//   req_ready  out  NREQ     one-hot grant (combinational)
//   hold       in   1        stall: no grant while 1
//   WMWE       out  1        memory write enable (registered)
//   WMWAR      out  AW       memory write address (registered)
//   WMWDR      out  DW       memory write data (registered)
//   grant_id   out  3        index of last accepted requester (registered)
//   wr_count   out  CW       writes issued since reset, wraps silently
//   idle       out  1        no request pending and no write in flight
// ---------------------------------------------------------------------------
module wm_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 13,
  parameter int DW   = 128,
  parameter int CW   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic              WMWE,
  output logic [AW-1:0]     WMWAR,
  output logic [DW-1:0]     WMWDR,
  output logic [2:0]        grant_id,
  output logic [CW-1:0]     wr_count,
  output logic              idle
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic            r_wmwe;
  logic [AW-1:0]   r_wmwar;
  logic [DW-1:0]   r_wmwdr;
  logic [2:0]      r_grant_id;
  logic [CW-1:0]   r_wr_count;

  logic            w_gnt_any;
  logic [PW-1:0]   w_gnt_idx;
  logic [NREQ-1:0] w_gnt_oh;
  logic [PW:0]     w_idx;
  logic [PW-1:0]   w_next_ptr;

  // Rotating search from r_ptr. w_idx carries one extra bit, so ptr+k can
  // exceed NREQ-1 before it is folded back into range. Reset gates the
  // grant, so no requester sees ready while reset is asserted.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) begin
        w_idx = w_idx - (PW+1)'(NREQ);
      end
      if (!w_gnt_any && req_valid[w_idx[PW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_idx[PW-1:0];
      end
    end
    if (hold || !reset) begin
      w_gnt_any = 1'b0;
    end
    if (w_gnt_any) begin
      w_gnt_oh[w_gnt_idx] = 1'b1;
    end
  end

  // The pointer moves past the requester just served, so it can never
  // hold an index >= NREQ.
  always_comb begin
    if (w_gnt_idx == PW'(NREQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr      <= '0;
      r_wmwe     <= 1'b0;
      r_wmwar    <= '0;
      r_wmwdr    <= '0;
      r_grant_id <= '0;
      r_wr_count <= '0;
    end else if (w_gnt_any) begin
      r_ptr      <= w_next_ptr;
      r_wmwe     <= 1'b1;
      r_wmwar    <= req_addr[w_gnt_idx*AW +: AW];
      r_wmwdr    <= req_data[w_gnt_idx*DW +: DW];
      r_grant_id <= 3'(w_gnt_idx);
      r_wr_count <= r_wr_count + CW'(1);
    end else begin
      r_wmwe     <= 1'b0;
    end
  end

  assign req_ready = w_gnt_oh;
  assign WMWE      = r_wmwe;
  assign WMWAR     = r_wmwar;
  assign WMWDR     = r_wmwdr;
  assign grant_id  = r_grant_id;
  assign wr_count  = r_wr_count;
  assign idle      = ~|req_valid & ~r_wmwe;

endmodule

// File: tb/tb_wm_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wm_write_arbiter
//
// Directed bench for wm_write_arbiter. A small working-memory model captures
// every committed write. A second instance with a 4-bit counter shares the
// same stimulus and shows the wr_count wrap.
// ---------------------------------------------------------------------------
module tb_wm_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 13;
  localparam int DW   = 128;
  localparam int CW   = 16;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              hold;
  logic              WMWE;
  logic [AW-1:0]     WMWAR;
  logic [DW-1:0]     WMWDR;
  logic [2:0]        grant_id;
  logic [CW-1:0]     wr_count;
  logic              idle;

  logic [NREQ-1:0]   w4_req_ready;
  logic              w4_wmwe;
  logic [AW-1:0]     w4_wmwar;
  logic [DW-1:0]     w4_wmwdr;
  logic [2:0]        w4_grant_id;
  logic [3:0]        w4_wr_count;
  logic              w4_idle;

  int errors = 0;
  int checks = 0;
  int commits = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  wm_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .WMWE(WMWE),
    .WMWAR(WMWAR), .WMWDR(WMWDR), .grant_id(grant_id), .wr_count(wr_count),
    .idle(idle)
  );

  wm_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(4)) u_dut_w (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(w4_req_ready), .hold(hold), .WMWE(w4_wmwe),
    .WMWAR(w4_wmwar), .WMWDR(w4_wmwdr), .grant_id(w4_grant_id),
    .wr_count(w4_wr_count), .idle(w4_idle)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Working-memory model: commits the registered write at the next edge.
  always @(posedge clock) begin
    if (WMWE) begin
      mem[WMWAR] <= WMWDR;
      commits    <= commits + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    hold      = 1'b0;
    reset     = 1'b0;
    tick();
    reset     = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    reset     = 1'b0;
    hold      = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      checks++; if (WMWE !== 1'b0) begin errors++; $display("FAIL reset_wmwe: got %b want 0", WMWE); end
      checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", wr_count); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b want 0", idle); end
      tick();
    end
    req_valid = '0;
    reset     = 1'b1;
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle_released: got %b want 1", idle); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 13'h0A5, 128'hDEAD);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
      tick();
      checks++; if (WMWE !== 1'b1) begin errors++; $display("FAIL single_wmwe: got %b want 1", WMWE); end
      checks++; if (WMWAR !== 13'h0A5) begin errors++; $display("FAIL single_addr: got %h want 0a5", WMWAR); end
      checks++; if (WMWDR !== 128'hDEAD) begin errors++; $display("FAIL single_data: got %h want dead", WMWDR); end
    end
    req_valid = '0;
    tick();
    checks++; if (WMWE !== 1'b0) begin errors++; $display("FAIL single_wmwe_off: got %b want 0", WMWE); end
    checks++; if (mem[13'h0A5] !== 128'hDEAD) begin errors++; $display("FAIL single_mem: got %h want dead", mem[13'h0A5]); end
    checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL single_count: got %0d want 3", wr_count); end
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL single_gid: got %0d want 2", grant_id); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 13'(13'h100 + i), 128'(32'h1000 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      tick();
      checks++; if (grant_id !== 3'(k % 4)) begin errors++; $display("FAIL contention_gid[%0d]: got %0d want %0d", k, grant_id, k % 4); end
      checks++; if (WMWAR !== 13'(13'h100 + k % 4)) begin errors++; $display("FAIL contention_addr[%0d]: got %h want %h", k, WMWAR, 13'h100 + k % 4); end
    end
    checks++; if (wr_count !== 16'd8) begin errors++; $display("FAIL contention_count: got %0d want 8", wr_count); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    set_req(1, 13'h011, 128'h11);
    set_req(2, 13'h022, 128'h22);
    set_req(3, 13'h033, 128'h33);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rot_ready0: got %b want 0100", req_ready); end
    tick();
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL rot_gid0: got %0d want 2", grant_id); end
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rot_ready1: got %b want 1000", req_ready); end
    tick();
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL rot_gid1: got %0d want 3", grant_id); end
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rot_ready2: got %b want 0010", req_ready); end
    tick();
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL rot_gid2: got %0d want 1", grant_id); end
    checks++; if (WMWAR !== 13'h011) begin errors++; $display("FAIL rot_addr2: got %h want 011", WMWAR); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 13'(13'h200 + i), 128'(32'h2000 + i));
    req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL hold_pre_gid: got %0d want 3", grant_id); end
    hold = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready0: got %b want 0000", req_ready); end
    checks++; if (WMWE !== 1'b1) begin errors++; $display("FAIL hold_wmwe_tail: got %b want 1", WMWE); end
    tick();
    checks++; if (WMWE !== 1'b0) begin errors++; $display("FAIL hold_wmwe_fall: got %b want 0", WMWE); end
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready1: got %b want 0000", req_ready); end
    tick();
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL hold_count: got %0d want 4", wr_count); end
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_resume_ready: got %b want 0001", req_ready); end
    tick();
    checks++; if (grant_id !== 3'd0 || WMWE !== 1'b1) begin errors++; $display("FAIL hold_resume_gid: got %0d/%b want 0/1", grant_id, WMWE); end
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_resume_next: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();

    // Two requesters writing the same address: the later grant must win.
    do_reset();
    set_req(0, 13'h010, 128'd1);
    set_req(1, 13'h010, 128'd2);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL coll_ready0: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL coll_ready1: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (mem[13'h010] !== 128'd2) begin errors++; $display("FAIL coll_mem: got %h want 2", mem[13'h010]); end
  endtask

  task automatic test_wrap_and_reset();
    int c0;
    do_reset();
    set_req(0, 13'h1F0, 128'hBEEF);
    req_valid = 4'b0001;
    for (int c = 0; c < 17; c++) tick();
    checks++; if (w4_wr_count !== 4'd1) begin errors++; $display("FAIL wrap_count4: got %0d want 1", w4_wr_count); end
    checks++; if (wr_count !== 16'd17) begin errors++; $display("FAIL wrap_count16: got %0d want 17", wr_count); end
    checks++; if (WMWE !== 1'b1) begin errors++; $display("FAIL midreset_pre: got %b want 1", WMWE); end
    c0 = commits;
    reset = 1'b0;
    #1;
    checks++; if (WMWE !== 1'b0) begin errors++; $display("FAIL midreset_wmwe: got %b want 0", WMWE); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", wr_count); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midreset_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (commits !== c0) begin errors++; $display("FAIL midreset_commit: got %0d want %0d", commits, c0); end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_hold();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
